// File: rtl/huff_pkg.sv
// Shared constants, types and record helper for the 4-symbol Huffman tree builder.
package huff_pkg;

  localparam int unsigned REC_W         = 13;
  localparam int unsigned ID_W          = 4;
  localparam int unsigned REC_ID_MSB    = 12;
  localparam int unsigned REC_ID_LSB    = 9;
  localparam int unsigned REC_EDGE_BIT  = 8;
  localparam int unsigned REC_LEFT_MSB  = 7;
  localparam int unsigned REC_LEFT_LSB  = 4;
  localparam int unsigned REC_RIGHT_MSB = 3;
  localparam int unsigned REC_RIGHT_LSB = 0;

  localparam int unsigned NUM_NODES     = 7;
  localparam int unsigned FIRST_LEAF_ID = 1;
  localparam int unsigned LAST_LEAF_ID  = 4;
  localparam int unsigned FIRST_INT_ID  = 5;
  localparam int unsigned ROOT_ID       = 7;

  typedef logic [ID_W-1:0]  node_id_t;
  typedef logic [REC_W-1:0] node_rec_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StMerge,
    StDone
  } huff_state_e;

  function automatic node_rec_t make_rec(node_id_t id, logic edge_bit, node_id_t left,
                                         node_id_t right);
    node_rec_t r;
    r = '0;
    r[REC_ID_MSB:REC_ID_LSB]       = id;
    r[REC_EDGE_BIT]                = edge_bit;
    r[REC_LEFT_MSB:REC_LEFT_LSB]   = left;
    r[REC_RIGHT_MSB:REC_RIGHT_LSB] = right;
    return r;
  endfunction

endpackage

// File: rtl/huffman_tree_builder_if.sv
// Start/weight request and node-record result bundle of the tree builder.
// root_weight exists only when HUFF_ROOT_WEIGHT_EN is defined.
interface huffman_tree_builder_if
  import huff_pkg::*;
#(
  parameter int unsigned WEIGHT_W = 8
) ();

  logic                start;
  logic [WEIGHT_W-1:0] weight_1;
  logic [WEIGHT_W-1:0] weight_2;
  logic [WEIGHT_W-1:0] weight_3;
  logic [WEIGHT_W-1:0] weight_4;
  node_rec_t           info_node_1;
  node_rec_t           info_node_2;
  node_rec_t           info_node_3;
  node_rec_t           info_node_4;
  node_rec_t           info_node_5;
  node_rec_t           info_node_6;
  node_rec_t           info_node_7;
  logic                busy;
  logic                done;
`ifdef HUFF_ROOT_WEIGHT_EN
  logic [WEIGHT_W+1:0] root_weight;

  modport master (
    output start, weight_1, weight_2, weight_3, weight_4,
    input  info_node_1, info_node_2, info_node_3, info_node_4, info_node_5, info_node_6,
    input  info_node_7, busy, done, root_weight
  );

  modport slave (
    input  start, weight_1, weight_2, weight_3, weight_4,
    output info_node_1, info_node_2, info_node_3, info_node_4, info_node_5, info_node_6,
    output info_node_7, busy, done, root_weight
  );
`else
  modport master (
    output start, weight_1, weight_2, weight_3, weight_4,
    input  info_node_1, info_node_2, info_node_3, info_node_4, info_node_5, info_node_6,
    input  info_node_7, busy, done
  );

  modport slave (
    input  start, weight_1, weight_2, weight_3, weight_4,
    output info_node_1, info_node_2, info_node_3, info_node_4, info_node_5, info_node_6,
    output info_node_7, busy, done
  );
`endif

endinterface

// File: rtl/huff_min2_tracker.sv
// Streaming two-smallest tracker: one (valid, id, weight) slot per cycle, lower id wins ties
// because slots arrive in ascending id order and replacement needs a strictly smaller weight.
module huff_min2_tracker
  import huff_pkg::*;
#(
  parameter int unsigned WeightW = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               valid_i,
  input  node_id_t           id_i,
  input  logic [WeightW-1:0] weight_i,
  output node_id_t           min1_id_o,
  output node_id_t           min2_id_o
);

  logic               min1_vld_q, min1_vld_d, min2_vld_q, min2_vld_d;
  node_id_t           min1_id_q, min1_id_d, min2_id_q, min2_id_d;
  logic [WeightW-1:0] min1_w_q, min1_w_d, min2_w_q, min2_w_d;
  logic               base1_vld, base2_vld;

  always_comb begin
    // Clear lands on the same cycle as the first slot, so that slot sees an empty tracker.
    base1_vld  = min1_vld_q & ~clr_i;
    base2_vld  = min2_vld_q & ~clr_i;
    min1_vld_d = base1_vld;
    min1_id_d  = min1_id_q;
    min1_w_d   = min1_w_q;
    min2_vld_d = base2_vld;
    min2_id_d  = min2_id_q;
    min2_w_d   = min2_w_q;
    if (valid_i) begin
      if (!base1_vld || (weight_i < min1_w_q)) begin
        min2_vld_d = base1_vld;
        min2_id_d  = min1_id_q;
        min2_w_d   = min1_w_q;
        min1_vld_d = 1'b1;
        min1_id_d  = id_i;
        min1_w_d   = weight_i;
      end else if (!base2_vld || (weight_i < min2_w_q)) begin
        min2_vld_d = 1'b1;
        min2_id_d  = id_i;
        min2_w_d   = weight_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min1_vld_q <= 1'b0;
      min1_id_q  <= '0;
      min1_w_q   <= '0;
      min2_vld_q <= 1'b0;
      min2_id_q  <= '0;
      min2_w_q   <= '0;
    end else begin
      min1_vld_q <= min1_vld_d;
      min1_id_q  <= min1_id_d;
      min1_w_q   <= min1_w_d;
      min2_vld_q <= min2_vld_d;
      min2_id_q  <= min2_id_d;
      min2_w_q   <= min2_w_d;
    end
  end

  assign min1_id_o = min1_id_q;
  assign min2_id_o = min2_id_q;

endmodule

// File: rtl/huffman_tree_builder.sv
// 4-leaf Huffman tree builder: LOAD, three (7-slot SCAN + MERGE) rounds, then a done pulse.
// Optional root_weight output is enabled by defining HUFF_ROOT_WEIGHT_EN.
module huffman_tree_builder
  import huff_pkg::*;
#(
  parameter int unsigned WEIGHT_W = 8
) (
  input logic                    CLK,
  input logic                    nRST,
  huffman_tree_builder_if.slave  bus
);

  localparam int unsigned SumW = WEIGHT_W + 2;
  typedef logic [SumW-1:0] sum_t;

  huff_state_e          state_q, state_d;
  sum_t                 w_q   [1:NUM_NODES];
  sum_t                 w_d   [1:NUM_NODES];
  node_rec_t            rec_q [1:NUM_NODES];
  node_rec_t            rec_d [1:NUM_NODES];
  logic [NUM_NODES:1]   active_q, active_d;
  logic [1:0]           round_q, round_d;
  logic [2:0]           slot_q, slot_d;
  logic                 busy_q, busy_d, done_q, done_d;
`ifdef HUFF_ROOT_WEIGHT_EN
  sum_t                 root_q, root_d;
`endif

  node_id_t min1_id, min2_id, parent_id;
  sum_t     min1_w, min2_w, merge_sum, scan_w;
  logic     scan_valid, scan_clr;

  assign parent_id = ID_W'(FIRST_INT_ID) + {2'b00, round_q};
  assign merge_sum = min1_w + min2_w;
  assign scan_clr  = (state_q == StScan) && (slot_q == 3'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad:  state_d = StScan;
      StScan:  if (slot_q == 3'(NUM_NODES)) state_d = StMerge;
      StMerge: state_d = (parent_id == ID_W'(ROOT_ID)) ? StDone : StScan;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Slot and merge-operand selection by id lookup into the weight registers.
  always_comb begin
    scan_valid = 1'b0;
    scan_w     = '0;
    min1_w     = '0;
    min2_w     = '0;
    for (int unsigned k = 1; k <= NUM_NODES; k++) begin
      if (slot_q == 3'(k)) begin
        scan_valid = active_q[k] && (state_q == StScan);
        scan_w     = w_q[k];
      end
      if (min1_id == ID_W'(k)) min1_w = w_q[k];
      if (min2_id == ID_W'(k)) min2_w = w_q[k];
    end
  end

  huff_min2_tracker #(
    .WeightW (SumW)
  ) u_min2 (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .clr_i     (scan_clr),
    .valid_i   (scan_valid),
    .id_i      ({1'b0, slot_q}),
    .weight_i  (scan_w),
    .min1_id_o (min1_id),
    .min2_id_o (min2_id)
  );

  always_comb begin
    w_d      = w_q;
    rec_d    = rec_q;
    active_d = active_q;
    round_d  = round_q;
    slot_d   = slot_q;
    busy_d   = (state_q == StLoad) || (state_q == StScan) || (state_q == StMerge);
    done_d   = (state_q == StDone);
`ifdef HUFF_ROOT_WEIGHT_EN
    root_d   = root_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          w_d[1] = {2'b00, bus.weight_1};
          w_d[2] = {2'b00, bus.weight_2};
          w_d[3] = {2'b00, bus.weight_3};
          w_d[4] = {2'b00, bus.weight_4};
        end
      end
      StLoad: begin
        for (int unsigned k = 1; k <= NUM_NODES; k++) begin
          if (k >= FIRST_LEAF_ID && k <= LAST_LEAF_ID) begin
            rec_d[k]    = make_rec(ID_W'(k), 1'b0, '0, '0);
            active_d[k] = 1'b1;
          end else begin
            rec_d[k]    = '0;
            w_d[k]      = '0;
            active_d[k] = 1'b0;
          end
        end
        round_d = '0;
        slot_d  = 3'd1;
      end
      StScan: begin
        slot_d = (slot_q == 3'(NUM_NODES)) ? 3'd1 : slot_q + 3'd1;
      end
      StMerge: begin
        for (int unsigned k = 1; k <= NUM_NODES; k++) begin
          if (parent_id == ID_W'(k)) begin
            w_d[k]      = merge_sum;
            rec_d[k]    = make_rec(parent_id, 1'b0, min1_id, min2_id);
            active_d[k] = 1'b1;
          end
          if (min1_id == ID_W'(k)) begin
            rec_d[k][REC_EDGE_BIT] = 1'b0;
            active_d[k]            = 1'b0;
          end
          if (min2_id == ID_W'(k)) begin
            rec_d[k][REC_EDGE_BIT] = 1'b1;
            active_d[k]            = 1'b0;
          end
        end
        round_d = round_q + 2'd1;
`ifdef HUFF_ROOT_WEIGHT_EN
        if (parent_id == ID_W'(ROOT_ID)) root_d = merge_sum;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 1; k <= NUM_NODES; k++) begin
        w_q[k]   <= '0;
        rec_q[k] <= '0;
      end
      active_q <= '0;
      round_q  <= '0;
      slot_q   <= 3'd1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef HUFF_ROOT_WEIGHT_EN
      root_q   <= '0;
`endif
    end else begin
      w_q      <= w_d;
      rec_q    <= rec_d;
      active_q <= active_d;
      round_q  <= round_d;
      slot_q   <= slot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef HUFF_ROOT_WEIGHT_EN
      root_q   <= root_d;
`endif
    end
  end

  assign bus.info_node_1 = rec_q[1];
  assign bus.info_node_2 = rec_q[2];
  assign bus.info_node_3 = rec_q[3];
  assign bus.info_node_4 = rec_q[4];
  assign bus.info_node_5 = rec_q[5];
  assign bus.info_node_6 = rec_q[6];
  assign bus.info_node_7 = rec_q[7];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef HUFF_ROOT_WEIGHT_EN
  assign bus.root_weight = root_q;
`endif

endmodule

// File: doc/huffman_tree_builder.md
# huffman_tree_builder

Builds the 4-symbol Huffman tree for the encoder datapath. It accepts four leaf weights on a start pulse, performs three serial merge rounds, and writes the seven 13-bit node records (`info_node_1`..`info_node_7`). These are the same records the downstream tree-walk and state-extraction blocks consume. It is the producer side of the node-record interface; consumers sample the records after `done`.

## Interface
Parameters
- `WEIGHT_W`, 8: leaf weight width. Internal sums are `WEIGHT_W+2` bits wide, so a 4-leaf total cannot overflow.

Ports
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `weight_1`..`weight_4`  in  `WEIGHT_W` each  leaf weights for node ids 1..4; captured on the edge that accepts `start`.
- `info_node_1`..`info_node_7`  out  13 each  node records, registered.
- `busy`  out  1  high from LOAD through the last MERGE.
- `done`  out  1  one-cycle pulse when all records are valid.

Node record format (bit ranges):
- [12:9] node id
- [8] edge bit from parent: 0 = left/smaller, 1 = right
- [7:4] left child id
- [3:0] right child id

Leaves have both child fields 4'h0, so for a leaf [7:4]==[3:0]. Internal nodes are ids 5, 6 and 7; 7 is the root, and its edge bit is always 0.

## Operation
- States: IDLE → LOAD → (SCAN ×7 → MERGE) ×3 → DONE → IDLE.
- IDLE: when `start`=1, latch the weights and go to LOAD. While busy, `start` is ignored (not queued).
- LOAD:
  - Clear all records.
  - Write leaf records {id,0,0,0} for ids 1..4.
  - Load weight registers w[1..4]. w[5..7] = 0.
  - Active mask = ids 1..4. Round counter = 0.
- SCAN: visit slot k = 1..7, one slot per cycle. Inactive slots are skipped but still consume their cycle.
  - Track min1 and min2 (id, weight) with strict less-than compare.
  - Ties go to the lower id, which follows from the ascending scan order.
- MERGE: p = 5 + round.
  - w[p] = w[min1] + w[min2].
  - Record p = {p, 0, min1, min2}.
  - Set edge bit of record min1 to 0 and of record min2 to 1.
  - Clear active[min1] and active[min2]; set active[p].
  - Increment round. After round 2, go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- Records hold their values until the next LOAD. Records are partially updated during a build; consumers must not sample while `busy`.
- Zero weights are legal and processed normally.

## Timing
- Reset values: all records 13'h0000, `busy`=0, `done`=0, state IDLE, mask empty.
- Counting from the edge that accepts `start` (edge 0):
  - LOAD at edge 1.
  - Rounds occupy edges 2..25; each round is 8 cycles (7 SCAN + 1 MERGE).
  - `done` is high in the cycle after edge 26.
  - Fixed latency: 26 cycles from start to done.
- `busy` rises at edge 1 and falls at edge 26.
- If `start` is held high, the block restarts on the first IDLE cycle after DONE: back-to-back builds with a 1-cycle IDLE gap.
- Reset asserted mid-build aborts immediately to IDLE with reset values. No `done` is issued.

## Configuration
- `HUFF_ROOT_WEIGHT_EN` defined:
  - Adds output port `root_weight` [`WEIGHT_W+1`:0], registered, reset 0.
  - Loaded with w[7] in the final MERGE; stable from `done` onward.
- Undefined: the port is absent; behaviour is otherwise identical.

## Structure
- Package `huff_pkg` holds:
  - Record field bit positions.
  - Node id constants (leaves 1..4, internal 5..7, ROOT_ID=7).
  - The state encoding.
  - The 13-bit record width.
- Sub-module `huff_min2_tracker`:
  - Streams (valid, id, weight) one slot per cycle.
  - Holds min1/min2 with lower-id tie-break.
  - Has a synchronous clear asserted at the first SCAN slot of each round.

## Test plan
- Weights 5,9,12,13 → after `done`:
  - node1..node4 = 13'h0200, 13'h0500, 13'h0600, 13'h0900
  - node5 = 13'h0A12, node6 = 13'h0D34, node7 = 13'h0E56
  - root_weight = 39
- Weights 20,1,1,30:
  - node5 = 13'h0A23 (weight 2)
  - node6 = 13'h0C51 (weight 22)
  - node7 = 13'h0E64
  - node1 = 13'h0300, node4 = 13'h0900
- All weights 7 (ties throughout) → node5 = 13'h0A12, node6 = 13'h0D34, node7 = 13'h0E56.
- Pulse `start` at edge 0; pulse it again at edge 10:
  - `done` appears exactly once, in the cycle after edge 26.
  - The second pulse is ignored.
  - `busy` is high for edges 1..25.
- Drop `nRST` at edge 12 of a build:
  - All records read 0 and `busy`=0 immediately.
  - No `done`.
  - A subsequent start yields correct records.
- Weights 255,255,255,255 → root_weight = 10'h3FC; no overflow in w[5..7].
